pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL have ports, in this order (name  direction  width  meaning):
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- IMEM_REQ  out  1  instruction-memory read request.
- IMEM_ADDR  out  32  word address of the request.
- IMEM_ACK  in  1  read complete; IMEM_RDATA valid this cycle.
- IMEM_RDATA  in  32  fetched instruction.
- INSTR_VALID  out  1  INSTR/PC valid toward decode.
- INSTR_READY  in  1  decode/execute accepts INSTR this cycle.
- INSTR  out  32  held instruction.
- PC  out  32  address of INSTR.
- PC_PLUS4  out  32  PC+4, the link value for JAL/JALR.
- BRANCH  in  1  held instruction is a conditional branch.
- BRANCHFLAG  in  1  ALU branch result; 1 = taken.
- JUMP  in  1  held instruction is JAL.
- JALR  in  1  held instruction is JALR.
- IMM  in  32  sign-extended branch/jump offset.
- ALU_OUT  in  32  ALU result, the JALR target (rs1+imm).
- TRAP  out  1  misaligned-target pulse.
- TRAP_ADDR  out  32  offending target.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, HOLD, TRAPPED.
REQ-004 IDLE: lasts one cycle after reset; goes to REQ with IMEM_ADDR=RESET_PC.
REQ-005 REQ: IMEM_REQ=1; IMEM_ADDR SHALL stay stable until IMEM_ACK.
REQ-006 On IMEM_ACK in REQ: capture IMEM_RDATA into INSTR and IMEM_ADDR into PC; next state HOLD. An ACK in the first REQ cycle SHALL be accepted.
REQ-007 HOLD: INSTR_VALID=1; INSTR, PC and PC_PLUS4 SHALL stay stable until INSTR_READY.
REQ-008 On INSTR_VALID&&INSTR_READY: sample BRANCH/BRANCHFLAG/JUMP/JALR/IMM/ALU_OUT that cycle; compute the next address; next state REQ.
REQ-009 Next-address priority: JALR -> {ALU_OUT[31:1],1'b0}; else JUMP -> PC+IMM; else BRANCH&&BRANCHFLAG -> PC+IMM; else PC+4.
REQ-010 Address arithmetic SHALL be 32-bit modulo 2^32: PC=32'hFFFF_FFFC with no branch gives 32'h0000_0000.
REQ-011 IMEM_ACK outside REQ SHALL be ignored. Control inputs outside the accept cycle SHALL be ignored.
REQ-012 Steady-state throughput with zero-wait memory SHALL be one instruction per 2 cycles. Accept-to-next-IMEM_REQ latency SHALL be 1 cycle.
REQ-013 IMEM_REQ and INSTR_VALID SHALL never be high in the same cycle.

Reset
REQ-014 While RST=1 at a clock edge: state=IDLE; IMEM_REQ=0; INSTR_VALID=0; TRAP=0; INSTR=0; PC=RESET_PC; IMEM_ADDR=RESET_PC; TRAP_ADDR=0.
REQ-015 RST SHALL abort any outstanding request or held instruction. An ACK in the reset cycle SHALL be discarded. TRAPPED SHALL be left only by RST.

Configuration
REQ-016 Macro MISALIGN_TRAP_EN defined: a next address with [1:0]!=0 SHALL pulse TRAP for exactly one cycle, set TRAP_ADDR to that address and enter TRAPPED. No further IMEM_REQ and INSTR_VALID=0 until RST.
REQ-017 Macro MISALIGN_TRAP_EN undefined: next address bits [1:0] SHALL be forced to 00; TRAP and TRAP_ADDR SHALL be tied to 0; TRAPPED SHALL be unreachable.

Verification
REQ-018 Reset, ACK same cycle as REQ, READY always 1 -> IMEM_ADDR sequence 0x0, 0x4, 0x8; one fetch per 2 cycles.
REQ-019 PC=0x100, BRANCH=1, BRANCHFLAG=1, IMM=0xFFFFFFF0 at accept -> next IMEM_ADDR=0xF0. Same with BRANCHFLAG=0 -> next IMEM_ADDR=0x104.
REQ-020 JALR=1, JUMP=1, ALU_OUT=0x2001 at accept -> next IMEM_ADDR=0x2000; PC_PLUS4 equals PC+4 throughout HOLD.
REQ-021 ACK delayed 3 cycles and INSTR_READY withheld 2 cycles -> IMEM_ADDR and INSTR stable throughout; no duplicate fetch.
REQ-022 RST asserted in REQ with ACK in the same cycle -> ACK discarded, INSTR_VALID=0, next fetch from RESET_PC.
REQ-023 With MISALIGN_TRAP_EN: JUMP, PC=0x10, IMM=0x6 -> TRAP high one cycle, TRAP_ADDR=0x16, no IMEM_REQ until RST. Without the macro: next IMEM_ADDR=0x14.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - instruction fetch sequencer with branch/jump redirect; MISALIGN_TRAP_EN enables misaligned-target trap
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [31:0] INSTR,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    input  logic        BRANCH,
    input  logic        BRANCHFLAG,
    input  logic        JUMP,
    input  logic        JALR,
    input  logic [31:0] IMM,
    input  logic [31:0] ALU_OUT,
    output logic        TRAP,
    output logic [31:0] TRAP_ADDR
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, TRAPPED} state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, instr_q, pc_q;
    logic [31:0] target, next_addr;
    logic        accept, ack_take, misaligned;

    assign accept   = (state == HOLD) && INSTR_READY;
    assign ack_take = (state == REQ) && IMEM_ACK;

    // Control inputs only matter in the accept cycle; the target is qualified by accept below.
    always_comb begin
        target = pc_q + 32'd4;
        if (JALR)
            target = {ALU_OUT[31:1], 1'b0};
        else if (JUMP || (BRANCH && BRANCHFLAG))
            target = pc_q + IMM;
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (target[1:0] != 2'b00);
    assign next_addr  = target;
`else
    assign misaligned = 1'b0;
    assign next_addr  = target & ~32'd3;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        IMEM_REQ    = 1'b0;
        INSTR_VALID = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                IMEM_REQ = 1'b1;
                if (IMEM_ACK)
                    state_next = HOLD;
            end
            HOLD: begin
                INSTR_VALID = 1'b1;
                if (INSTR_READY)
                    state_next = misaligned ? TRAPPED : REQ;
            end
            TRAPPED: state_next = TRAPPED;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= RESET_PC;
            instr_q <= 32'd0;
            pc_q    <= RESET_PC;
        end else begin
            if (ack_take) begin
                instr_q <= IMEM_RDATA;
                pc_q    <= addr_q;
            end
            if (accept && !misaligned)
                addr_q <= next_addr;
        end
    end

    assign IMEM_ADDR = addr_q;
    assign INSTR     = instr_q;
    assign PC        = pc_q;
    assign PC_PLUS4  = pc_q + 32'd4;

`ifdef MISALIGN_TRAP_EN
    logic        trap_q;
    logic [31:0] trap_addr_q;

    // TRAP is a one-cycle pulse; TRAP_ADDR keeps the offending target until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            trap_q      <= 1'b0;
            trap_addr_q <= 32'd0;
        end else begin
            trap_q <= accept && misaligned;
            if (accept && misaligned)
                trap_addr_q <= target;
        end
    end

    assign TRAP      = trap_q;
    assign TRAP_ADDR = trap_addr_q;
`else
    assign TRAP      = 1'b0;
    assign TRAP_ADDR = 32'd0;
`endif

endmodule
